io_bus_arbiter: RTL and testbench
=================================

IO_BUS_ARBITER -- requirements
Module: io_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 256: cycles a granted strobe may wait for s_ack_i/s_err_i before a forced error.
REQ-002 clk_i  in  1  single clock; all state changes on rising edge.
REQ-003 rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 Wishbone cycle, strobe, write enable.
REQ-005 m0_addr_i  in  32; m0_addr_tag_i  in  3 (mode[2:1], lock/unlock[0]); m0_data_i  in  32; m0_sel_i  in  4.
REQ-006 m0_ack_o, m0_err_o, m0_data_tag_o  out  1 each; m0_data_o  out  32  master 0 response.
REQ-007 m1_* ports: same names, directions and widths as m0_*, for master 1.
REQ-008 s_cyc_o, s_stb_o, s_we_o  out  1; s_addr_o  out  32; s_addr_tag_o  out  3; s_data_o  out  32; s_sel_o  out  4  to io_bus.
REQ-009 s_ack_i, s_err_i, s_data_tag_i  in  1; s_data_i  in  32  from io_bus.

Function
REQ-010 The FSM SHALL have states IDLE, OWN0 and OWN1; a registered grant, 1-cycle arbitration latency from cyc_i to s_cyc_o.
REQ-011 In IDLE, all s_* outputs and all m*_ack_o/err_o/data_o/data_tag_o SHALL be 0.
REQ-012 IDLE with exactly one mX_cyc_i high -> OWNX; with both high -> the master that did not own last (last_q), round-robin.
REQ-013 In OWNX, s_* SHALL equal mX_* combinationally, and mX_ack_o/err_o/data_o/data_tag_o SHALL equal s_*_i; the non-owner's response outputs SHALL be 0.
REQ-014 Ownership holds while mX_cyc_i is high; when it drops with lock_q clear, the next state is OWN(other) if other cyc_i is high, else IDLE (same-edge handoff).
REQ-015 lock_q SHALL set on s_ack_i of an owner transfer tagged {AMO, LOCK} and clear on s_ack_i or s_err_i of an owner transfer tagged {AMO, UNLOCK}.
REQ-016 While lock_q is set, ownership SHALL NOT move even if owner cyc_i drops; s_cyc_o/s_stb_o follow owner inputs.
REQ-017 A 9-bit wait counter SHALL count cycles with s_stb_o high and s_ack_i, s_err_i low; cleared on ack, err or stb low.
REQ-018 When the counter reaches TIMEOUT_CYCLES-1, owner err_o SHALL pulse 1 cycle, s_stb_o/s_cyc_o forced 0 that cycle, counter and lock_q cleared.
REQ-019 s_err_i on any owner transfer SHALL clear lock_q.
REQ-020 last_q SHALL update to X on every entry to OWNX.

Reset
REQ-021 rst_ni low SHALL immediately force state IDLE, lock_q 0, counter 0, last_q 1 (master 0 first), all outputs 0, including mid-transfer.
REQ-022 Release of rst_ni SHALL require one clock edge before any grant.

Structure
REQ-023 Package io_arb_pkg SHALL hold the state enum and TIMEOUT default; tag codes SHALL come from tags.svh.
REQ-024 The wait counter SHALL be sub-module io_bus_watchdog (inputs stb/ack/err, output expire pulse).

Verification
REQ-025 m0 read alone at 0x0000_0010: s_cyc_o high 1 cycle after m0_cyc_i; s_ack_i data 0xDEAD_BEEF -> m0_data_o 0xDEAD_BEEF, m1 outputs 0.
REQ-026 m0, m1 request same cycle after reset -> OWN0; m0 drops cyc while m1 holds -> OWN1 next edge, no IDLE cycle.
REQ-027 m1 AMO LOCK acked at 0x0000_0100, m1 drops cyc, m0 requests -> stays OWN1 until m1 AMO UNLOCK acked, then OWN0.
REQ-028 Slave never acks with TIMEOUT_CYCLES=8 -> owner err_o pulse on 8th strobe cycle, s_stb_o 0 that cycle, lock_q 0.
REQ-029 rst_ni asserted mid-transfer in OWN1 with lock_q set -> outputs 0 asynchronously; after release m0 and m1 together -> OWN0.

Source files
------------

// File: rtl/io_arb_pkg.sv
// Shared types and defaults for the two-master io_bus arbiter.
package io_arb_pkg;
  `include "tags.svh"

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 256;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;
endpackage

// File: rtl/io_bus_watchdog.sv
// Counts stalled strobe cycles and pulses expire on the cycle the limit is reached.
module io_bus_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic stb,
  input  logic ack,
  input  logic err,
  output logic expire
);
  localparam logic [8:0] TERM_CNT = 9'(TIMEOUT_CYCLES - 1);

  logic [8:0] wait_cnt_q;
  logic       waiting;

  assign waiting = stb & ~ack & ~err;
  assign expire  = waiting & (wait_cnt_q == TERM_CNT);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_cnt_q <= '0;
    end else if (!waiting || expire) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_q + 9'd1;
    end
  end
endmodule

// File: rtl/tags.svh
// Address-tag encodings for io_bus transfers: addr_tag = {mode[1:0], lock_unlock}.
`ifndef IO_TAGS_SVH
`define IO_TAGS_SVH
localparam logic [1:0] TAG_MODE_AMO = 2'b10;
localparam logic       TAG_LOCK     = 1'b1;
localparam logic       TAG_UNLOCK   = 1'b0;
`endif

// File: rtl/io_bus_arbiter.sv
// Two-master Wishbone arbiter for io_bus with round-robin grant, AMO bus lock and
// a stalled-strobe watchdog.
//   state   | meaning
//   IDLE    | no owner; all slave and response outputs held at 0
//   OWN0    | master 0 drives io_bus and receives its responses
//   OWN1    | master 1 drives io_bus and receives its responses
module io_bus_arbiter
  import io_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [2:0]  m0_addr_tag_i,
  input  logic [31:0] m0_data_i,
  input  logic [3:0]  m0_sel_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic        m0_data_tag_o,
  output logic [31:0] m0_data_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [2:0]  m1_addr_tag_i,
  input  logic [31:0] m1_data_i,
  input  logic [3:0]  m1_sel_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        m1_data_tag_o,
  output logic [31:0] m1_data_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_addr_o,
  output logic [2:0]  s_addr_tag_o,
  output logic [31:0] s_data_o,
  output logic [3:0]  s_sel_o,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  input  logic        s_data_tag_i,
  input  logic [31:0] s_data_i
);
  arb_state_e  state_q, state_d;
  logic        last_q, last_d;
  logic        lock_q, lock_d;
  logic        own0, own1;
  logic        o_cyc, o_stb, o_we;
  logic [31:0] o_addr, o_data;
  logic [2:0]  o_tag;
  logic [3:0]  o_sel;
  logic        expire, xfer, tag_lock, tag_unlock;

  assign own0 = (state_q == ST_OWN0);
  assign own1 = (state_q == ST_OWN1);

  always_comb begin
    o_cyc  = 1'b0;
    o_stb  = 1'b0;
    o_we   = 1'b0;
    o_addr = '0;
    o_tag  = '0;
    o_data = '0;
    o_sel  = '0;
    if (own0) begin
      o_cyc  = m0_cyc_i;
      o_stb  = m0_stb_i;
      o_we   = m0_we_i;
      o_addr = m0_addr_i;
      o_tag  = m0_addr_tag_i;
      o_data = m0_data_i;
      o_sel  = m0_sel_i;
    end else if (own1) begin
      o_cyc  = m1_cyc_i;
      o_stb  = m1_stb_i;
      o_we   = m1_we_i;
      o_addr = m1_addr_i;
      o_tag  = m1_addr_tag_i;
      o_data = m1_data_i;
      o_sel  = m1_sel_i;
    end
  end

  // Watchdog sees the owner's raw strobe so the forced-low output cannot feed back.
  io_bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .stb    (o_stb),
    .ack    (s_ack_i),
    .err    (s_err_i),
    .expire (expire)
  );

  assign s_cyc_o      = o_cyc & ~expire;
  assign s_stb_o      = o_stb & ~expire;
  assign s_we_o       = o_we;
  assign s_addr_o     = o_addr;
  assign s_addr_tag_o = o_tag;
  assign s_data_o     = o_data;
  assign s_sel_o      = o_sel;

  assign m0_ack_o      = own0 & s_ack_i;
  assign m0_err_o      = own0 & (s_err_i | expire);
  assign m0_data_tag_o = own0 & s_data_tag_i;
  assign m0_data_o     = own0 ? s_data_i : '0;
  assign m1_ack_o      = own1 & s_ack_i;
  assign m1_err_o      = own1 & (s_err_i | expire);
  assign m1_data_tag_o = own1 & s_data_tag_i;
  assign m1_data_o     = own1 ? s_data_i : '0;

  assign xfer       = o_cyc & o_stb;
  assign tag_lock   = (o_tag == {TAG_MODE_AMO, TAG_LOCK});
  assign tag_unlock = (o_tag == {TAG_MODE_AMO, TAG_UNLOCK});

  always_comb begin
    lock_d = lock_q;
    if (expire) begin
      lock_d = 1'b0;
    end else if (xfer) begin
      if (s_err_i)                     lock_d = 1'b0;
      else if (s_ack_i && tag_lock)    lock_d = 1'b1;
      else if (s_ack_i && tag_unlock)  lock_d = 1'b0;
    end
  end

  // A held lock pins ownership even after the owner drops cyc.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_d = last_q ? ST_OWN0 : ST_OWN1;
        else if (m0_cyc_i)        state_d = ST_OWN0;
        else if (m1_cyc_i)        state_d = ST_OWN1;
      end
      ST_OWN0: begin
        if (!m0_cyc_i && !lock_q) state_d = m1_cyc_i ? ST_OWN1 : ST_IDLE;
      end
      ST_OWN1: begin
        if (!m1_cyc_i && !lock_q) state_d = m0_cyc_i ? ST_OWN0 : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (state_d == ST_OWN0 && state_q != ST_OWN0)      last_d = 1'b0;
    else if (state_d == ST_OWN1 && state_q != ST_OWN1) last_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      lock_q  <= lock_d;
    end
  end
endmodule

// File: tb/tb_io_bus_arbiter.sv
// Randomized and directed bench for io_bus_arbiter against an ownership-level reference model.
module tb_io_bus_arbiter;
  localparam int TO = 8;
  localparam logic [2:0] TAG_LK = 3'b101;
  localparam logic [2:0] TAG_UL = 3'b100;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [31:0] m0_addr_i, m0_data_i;
  logic [2:0]  m0_addr_tag_i;
  logic [3:0]  m0_sel_i;
  logic        m0_ack_o, m0_err_o, m0_data_tag_o;
  logic [31:0] m0_data_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [31:0] m1_addr_i, m1_data_i;
  logic [2:0]  m1_addr_tag_i;
  logic [3:0]  m1_sel_i;
  logic        m1_ack_o, m1_err_o, m1_data_tag_o;
  logic [31:0] m1_data_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_addr_o, s_data_o;
  logic [2:0]  s_addr_tag_o;
  logic [3:0]  s_sel_o;
  logic        s_ack_i, s_err_i, s_data_tag_i;
  logic [31:0] s_data_i;

  always #5 clk_i = ~clk_i;

  io_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i),
    .m0_addr_tag_i(m0_addr_tag_i), .m0_data_i(m0_data_i), .m0_sel_i(m0_sel_i),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_data_tag_o(m0_data_tag_o), .m0_data_o(m0_data_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i),
    .m1_addr_tag_i(m1_addr_tag_i), .m1_data_i(m1_data_i), .m1_sel_i(m1_sel_i),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_data_tag_o(m1_data_tag_o), .m1_data_o(m1_data_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o),
    .s_addr_tag_o(s_addr_tag_o), .s_data_o(s_data_o), .s_sel_o(s_sel_o),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_data_tag_i(s_data_tag_i), .s_data_i(s_data_i)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: owner index (-1 = none), last granted master, lock flag, stall count.
  int   mo, mlast, mwcnt;
  bit   mlock;
  logic e_cyc, e_stb, e_we, e_exp;
  logic [31:0] e_addr, e_data;
  logic [2:0]  e_tag;
  logic [3:0]  e_sel;
  logic        e_ack[2], e_err[2], e_dtag[2];
  logic [31:0] e_dat[2];

  function automatic logic m_cyc(int i); return (i == 0) ? m0_cyc_i : m1_cyc_i; endfunction
  function automatic logic m_stb(int i); return (i == 0) ? m0_stb_i : m1_stb_i; endfunction
  function automatic logic m_we(int i);  return (i == 0) ? m0_we_i  : m1_we_i;  endfunction
  function automatic logic [31:0] m_addr(int i); return (i == 0) ? m0_addr_i : m1_addr_i; endfunction
  function automatic logic [31:0] m_data(int i); return (i == 0) ? m0_data_i : m1_data_i; endfunction
  function automatic logic [2:0]  m_tag(int i);  return (i == 0) ? m0_addr_tag_i : m1_addr_tag_i; endfunction
  function automatic logic [3:0]  m_sel(int i);  return (i == 0) ? m0_sel_i : m1_sel_i; endfunction

  task automatic model_reset();
    mo = -1; mlast = 1; mlock = 1'b0; mwcnt = 0;
  endtask

  task automatic model_outputs();
    e_cyc = 0; e_stb = 0; e_we = 0; e_addr = 0; e_data = 0; e_tag = 0; e_sel = 0; e_exp = 0;
    for (int i = 0; i < 2; i++) begin
      e_ack[i] = 0; e_err[i] = 0; e_dtag[i] = 0; e_dat[i] = 0;
    end
    if (rst_ni && mo >= 0) begin
      e_exp  = m_stb(mo) && !s_ack_i && !s_err_i && (mwcnt == TO - 1);
      e_cyc  = m_cyc(mo) && !e_exp;
      e_stb  = m_stb(mo) && !e_exp;
      e_we   = m_we(mo);
      e_addr = m_addr(mo);
      e_data = m_data(mo);
      e_tag  = m_tag(mo);
      e_sel  = m_sel(mo);
      e_ack[mo]  = s_ack_i;
      e_err[mo]  = s_err_i || e_exp;
      e_dat[mo]  = s_data_i;
      e_dtag[mo] = s_data_tag_i;
    end
  endtask

  task automatic model_update();
    int  nxt;
    bit  nlock, xfer;
    if (!rst_ni) begin
      model_reset();
      return;
    end
    model_outputs();
    nlock = mlock;
    xfer  = (mo >= 0) && m_cyc(mo) && m_stb(mo);
    if (e_exp) nlock = 0;
    else if (xfer && s_err_i) nlock = 0;
    else if (xfer && s_ack_i && m_tag(mo) == TAG_LK) nlock = 1;
    else if (xfer && s_ack_i && m_tag(mo) == TAG_UL) nlock = 0;
    if (mo < 0 || !m_stb(mo) || s_ack_i || s_err_i || e_exp) mwcnt = 0;
    else mwcnt = mwcnt + 1;
    if (mo < 0) begin
      if (m0_cyc_i && m1_cyc_i) nxt = 1 - mlast;
      else if (m0_cyc_i)        nxt = 0;
      else if (m1_cyc_i)        nxt = 1;
      else                      nxt = -1;
    end else if (m_cyc(mo) || mlock) begin
      nxt = mo;
    end else begin
      nxt = m_cyc(1 - mo) ? 1 - mo : -1;
    end
    if (nxt >= 0 && nxt != mo) mlast = nxt;
    mo = nxt;
    mlock = nlock;
  endtask

  task automatic compare_outputs(input string ctx);
    model_outputs();
    check_val({ctx, ".s_cyc"},  s_cyc_o, e_cyc);
    check_val({ctx, ".s_stb"},  s_stb_o, e_stb);
    check_val({ctx, ".s_we"},   s_we_o, e_we);
    check_val({ctx, ".s_addr"}, s_addr_o, e_addr);
    check_val({ctx, ".s_tag"},  s_addr_tag_o, e_tag);
    check_val({ctx, ".s_data"}, s_data_o, e_data);
    check_val({ctx, ".s_sel"},  s_sel_o, e_sel);
    check_val({ctx, ".m0_ack"}, m0_ack_o, e_ack[0]);
    check_val({ctx, ".m0_err"}, m0_err_o, e_err[0]);
    check_val({ctx, ".m0_dat"}, m0_data_o, e_dat[0]);
    check_val({ctx, ".m0_dtg"}, m0_data_tag_o, e_dtag[0]);
    check_val({ctx, ".m1_ack"}, m1_ack_o, e_ack[1]);
    check_val({ctx, ".m1_err"}, m1_err_o, e_err[1]);
    check_val({ctx, ".m1_dat"}, m1_data_o, e_dat[1]);
    check_val({ctx, ".m1_dtg"}, m1_data_tag_o, e_dtag[1]);
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step(input string ctx);
    #1 compare_outputs(ctx);
    @(posedge clk_i);
    model_update();
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    #2 rst_ni = 1'b0;
    model_reset();
    #1 compare_outputs("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic clear_inputs();
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_addr_i = 0; m0_addr_tag_i = 0; m0_data_i = 0; m0_sel_i = 0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_addr_i = 0; m1_addr_tag_i = 0; m1_data_i = 0; m1_sel_i = 0;
    s_ack_i = 0; s_err_i = 0; s_data_tag_i = 0; s_data_i = 0;
  endtask

  function automatic logic [2:0] rnd_tag();
    case ($urandom_range(0, 3))
      0:       return TAG_LK;
      1:       return TAG_UL;
      default: return 3'($urandom_range(0, 7));
    endcase
  endfunction

  initial begin
    bit noack;
    clear_inputs();
    rst_ni = 1'b0;
    model_reset();
    @(negedge clk_i);
    m0_cyc_i = 1; m0_stb_i = 1;
    #1 check_val("rst_scyc", s_cyc_o, 0);
    step("rst_hold");

    // single master read
    rst_ni = 1'b1;
    m0_addr_i = 32'h0000_0010; m0_sel_i = 4'hF; m0_we_i = 0;
    #1 check_val("rd_pre_scyc", s_cyc_o, 0);
    step("rd_arb");
    #1 check_val("rd_grant_scyc", s_cyc_o, 1);
    check_val("rd_grant_addr", s_addr_o, 32'h0000_0010);
    s_ack_i = 1; s_data_i = 32'hDEAD_BEEF;
    #1 check_val("rd_m0_data", m0_data_o, 32'hDEAD_BEEF);
    check_val("rd_m1_data", m1_data_o, 0);
    check_val("rd_m1_ack", m1_ack_o, 0);
    step("rd_ack");
    clear_inputs();
    step("rd_end");

    // simultaneous request after reset, then same-edge handoff
    do_reset();
    m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 32'h200;
    m1_cyc_i = 1; m1_stb_i = 1; m1_addr_i = 32'h300;
    step("rr_arb");
    #1 check_val("rr_first_addr", s_addr_o, 32'h200);
    m0_cyc_i = 0; m0_stb_i = 0;
    step("rr_hand");
    #1 check_val("rr_hand_addr", s_addr_o, 32'h300);
    check_val("rr_hand_scyc", s_cyc_o, 1);

    // lock held by m1 across its cyc drop
    m1_addr_i = 32'h100; m1_addr_tag_i = TAG_LK; s_ack_i = 1;
    step("lk_set");
    s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0; m1_addr_tag_i = 0;
    m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 32'h400;
    repeat (3) step("lk_hold");
    #1 check_val("lk_hold_addr", s_addr_o, 32'h100);
    s_ack_i = 1;
    #1 check_val("lk_hold_m0ack", m0_ack_o, 0);
    m1_cyc_i = 1; m1_stb_i = 1; m1_addr_tag_i = TAG_UL;
    step("lk_unlock");
    s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0; m1_addr_tag_i = 0;
    step("lk_release");
    #1 check_val("lk_m0_addr", s_addr_o, 32'h400);

    // watchdog expiry while m0 holds a lock
    m0_addr_tag_i = TAG_LK; s_ack_i = 1;
    step("wd_lock");
    m0_addr_tag_i = 0; s_ack_i = 0;
    for (int i = 1; i < TO; i++) begin
      #1 check_val("wd_wait_err", m0_err_o, 0);
      step("wd_wait");
    end
    #1 check_val("wd_exp_err", m0_err_o, 1);
    check_val("wd_exp_stb", s_stb_o, 0);
    check_val("wd_exp_cyc", s_cyc_o, 0);
    step("wd_exp");
    m0_cyc_i = 0; m0_stb_i = 0;
    m1_cyc_i = 1; m1_stb_i = 1; m1_addr_i = 32'h500;
    step("wd_drop");
    #1 check_val("wd_unlocked_addr", s_addr_o, 32'h500);

    // async reset during a locked m1 transfer
    m1_addr_tag_i = TAG_LK; s_ack_i = 1;
    step("ar_lock");
    m1_addr_tag_i = 0;
    #2 rst_ni = 1'b0;
    model_reset();
    #1 check_val("ar_scyc", s_cyc_o, 0);
    check_val("ar_sstb", s_stb_o, 0);
    check_val("ar_saddr", s_addr_o, 0);
    check_val("ar_m1ack", m1_ack_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1; s_ack_i = 0;
    m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 32'h600;
    step("ar_arb");
    #1 check_val("ar_own0_addr", s_addr_o, 32'h600);

    // randomized traffic
    noack = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0)  noack = 1;
      if (c % 200 == 25) noack = 0;
      if (m0_cyc_i) m0_cyc_i = ($urandom_range(0, 7) != 0);
      else          m0_cyc_i = ($urandom_range(0, 3) == 0);
      if (m1_cyc_i) m1_cyc_i = ($urandom_range(0, 7) != 0);
      else          m1_cyc_i = ($urandom_range(0, 3) == 0);
      m0_stb_i = m0_cyc_i && ($urandom_range(0, 3) != 0);
      m1_stb_i = m1_cyc_i && ($urandom_range(0, 3) != 0);
      m0_we_i = 1'($urandom); m1_we_i = 1'($urandom);
      m0_addr_i = $urandom; m1_addr_i = $urandom;
      m0_data_i = $urandom; m1_data_i = $urandom;
      m0_sel_i = 4'($urandom); m1_sel_i = 4'($urandom);
      m0_addr_tag_i = rnd_tag(); m1_addr_tag_i = rnd_tag();
      s_ack_i = !noack && ($urandom_range(0, 2) == 0);
      s_err_i = !noack && !s_ack_i && ($urandom_range(0, 19) == 0);
      s_data_i = $urandom; s_data_tag_i = 1'($urandom);
      if ($urandom_range(0, 399) == 0) do_reset();
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
